// File: rtl/rs_tagged_queue_if.sv
// Dispatch, CDB broadcast and issue signal bundle for one reservation station.
interface rs_tagged_queue_if #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned ROB_IDX_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned PAYLOAD_WIDTH = 96,
  parameter int unsigned NUM_CDB       = 2
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic                             flush;
  logic                             dispatch_valid;
  logic                             dispatch_ready;
  logic [PAYLOAD_WIDTH-1:0]         dispatch_payload;
  logic [ROB_IDX_WIDTH-1:0]         dispatch_rd_rob_idx;
  logic                             dispatch_rs1_ready;
  logic [DATA_WIDTH-1:0]            dispatch_rs1_data;
  logic [ROB_IDX_WIDTH-1:0]         dispatch_rs1_rob_idx;
  logic                             dispatch_rs2_ready;
  logic [DATA_WIDTH-1:0]            dispatch_rs2_data;
  logic [ROB_IDX_WIDTH-1:0]         dispatch_rs2_rob_idx;
  logic [NUM_CDB-1:0]               cdb_valid;
  logic [NUM_CDB*ROB_IDX_WIDTH-1:0] cdb_rob_idx;
  logic [NUM_CDB*DATA_WIDTH-1:0]    cdb_data;
  logic                             issue_valid;
  logic                             issue_ready;
  logic [PAYLOAD_WIDTH-1:0]         issue_payload;
  logic [DATA_WIDTH-1:0]            issue_rs1_data;
  logic [DATA_WIDTH-1:0]            issue_rs2_data;
  logic [ROB_IDX_WIDTH-1:0]         issue_rd_rob_idx;
  logic [OCC_W-1:0]                 occupancy;

  modport master (
    output flush, dispatch_valid, dispatch_payload, dispatch_rd_rob_idx,
           dispatch_rs1_ready, dispatch_rs1_data, dispatch_rs1_rob_idx,
           dispatch_rs2_ready, dispatch_rs2_data, dispatch_rs2_rob_idx,
           cdb_valid, cdb_rob_idx, cdb_data, issue_ready,
    input  dispatch_ready, issue_valid, issue_payload, issue_rs1_data,
           issue_rs2_data, issue_rd_rob_idx, occupancy
  );

  modport slave (
    input  flush, dispatch_valid, dispatch_payload, dispatch_rd_rob_idx,
           dispatch_rs1_ready, dispatch_rs1_data, dispatch_rs1_rob_idx,
           dispatch_rs2_ready, dispatch_rs2_data, dispatch_rs2_rob_idx,
           cdb_valid, cdb_rob_idx, cdb_data, issue_ready,
    output dispatch_ready, issue_valid, issue_payload, issue_rs1_data,
           issue_rs2_data, issue_rd_rob_idx, occupancy
  );
endinterface

// File: rtl/rs_tagged_queue.sv
// Reservation station: holds dispatched ops until both sources are ready,
// wakes sources from CDB broadcasts and issues the oldest ready entry.
module rs_tagged_queue #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned ROB_IDX_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned PAYLOAD_WIDTH = 96,
  parameter int unsigned NUM_CDB       = 2
) (
  input logic              clk,
  input logic              rst,
  rs_tagged_queue_if.slave rs
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned SRC_W = DATA_WIDTH + 1;

  logic [DEPTH-1:0]         valid_q,   valid_d;
  logic [DEPTH-1:0]         rs1_rdy_q, rs1_rdy_d;
  logic [DEPTH-1:0]         rs2_rdy_q, rs2_rdy_d;
  logic [PAYLOAD_WIDTH-1:0] payload_q  [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] payload_d  [DEPTH];
  logic [ROB_IDX_WIDTH-1:0] rd_tag_q   [DEPTH];
  logic [ROB_IDX_WIDTH-1:0] rd_tag_d   [DEPTH];
  logic [DATA_WIDTH-1:0]    rs1_data_q [DEPTH];
  logic [DATA_WIDTH-1:0]    rs1_data_d [DEPTH];
  logic [ROB_IDX_WIDTH-1:0] rs1_tag_q  [DEPTH];
  logic [ROB_IDX_WIDTH-1:0] rs1_tag_d  [DEPTH];
  logic [DATA_WIDTH-1:0]    rs2_data_q [DEPTH];
  logic [DATA_WIDTH-1:0]    rs2_data_d [DEPTH];
  logic [ROB_IDX_WIDTH-1:0] rs2_tag_q  [DEPTH];
  logic [ROB_IDX_WIDTH-1:0] rs2_tag_d  [DEPTH];
  // older_q[i][j] set: entry i was dispatched before entry j
  logic [DEPTH-1:0]         older_q    [DEPTH];
  logic [DEPTH-1:0]         older_d    [DEPTH];

  logic [DEPTH-1:0] cand, oldest;
  logic [IDX_W-1:0] sel_idx, alloc_idx;
  logic [OCC_W-1:0] occ;
  logic             disp_rdy, disp_fire, issue_fire;

  // Returns {ready, data}; an already-ready source keeps its value, lowest CDB port wins.
  function automatic logic [SRC_W-1:0] snoop(
    input logic                             rdy,
    input logic [DATA_WIDTH-1:0]            data,
    input logic [ROB_IDX_WIDTH-1:0]         tag,
    input logic [NUM_CDB-1:0]               v,
    input logic [NUM_CDB*ROB_IDX_WIDTH-1:0] tags,
    input logic [NUM_CDB*DATA_WIDTH-1:0]    datas
  );
    logic                  hit;
    logic [DATA_WIDTH-1:0] d;
    hit = rdy;
    d   = data;
    for (int k = int'(NUM_CDB) - 1; k >= 0; k--) begin
      if (!rdy && v[k] && (tags[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] == tag)) begin
        hit = 1'b1;
        d   = datas[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    return {hit, d};
  endfunction

  always_comb begin
    occ = '0;
    for (int i = 0; i < int'(DEPTH); i++) occ = occ + OCC_W'(valid_q[i]);
  end

  assign disp_rdy   = (occ < OCC_W'(DEPTH));
  assign disp_fire  = rs.dispatch_valid && disp_rdy && !rs.flush;
  assign issue_fire = (|cand) && rs.issue_ready;

  // Oldest candidate: no other candidate is older than it.
  always_comb begin
    cand    = valid_q & rs1_rdy_q & rs2_rdy_q;
    oldest  = '0;
    sel_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      oldest[i] = cand[i];
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (cand[j] && older_q[j][i]) oldest[i] = 1'b0;
      end
    end
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (oldest[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end
  end

  always_comb begin
    rs.issue_valid      = |cand;
    rs.issue_payload    = '0;
    rs.issue_rs1_data   = '0;
    rs.issue_rs2_data   = '0;
    rs.issue_rd_rob_idx = '0;
    if (|cand) begin
      rs.issue_payload    = payload_q[sel_idx];
      rs.issue_rs1_data   = rs1_data_q[sel_idx];
      rs.issue_rs2_data   = rs2_data_q[sel_idx];
      rs.issue_rd_rob_idx = rd_tag_q[sel_idx];
    end
  end

  assign rs.dispatch_ready = disp_rdy;
  assign rs.occupancy      = occ;

  always_comb begin
    valid_d    = valid_q;
    rs1_rdy_d  = rs1_rdy_q;
    rs2_rdy_d  = rs2_rdy_q;
    payload_d  = payload_q;
    rd_tag_d   = rd_tag_q;
    rs1_data_d = rs1_data_q;
    rs1_tag_d  = rs1_tag_q;
    rs2_data_d = rs2_data_q;
    rs2_tag_d  = rs2_tag_q;
    older_d    = older_q;

    for (int i = 0; i < int'(DEPTH); i++) begin
      {rs1_rdy_d[i], rs1_data_d[i]} = snoop(rs1_rdy_q[i], rs1_data_q[i], rs1_tag_q[i],
                                            rs.cdb_valid, rs.cdb_rob_idx, rs.cdb_data);
      {rs2_rdy_d[i], rs2_data_d[i]} = snoop(rs2_rdy_q[i], rs2_data_q[i], rs2_tag_q[i],
                                            rs.cdb_valid, rs.cdb_rob_idx, rs.cdb_data);
    end

    if (issue_fire) valid_d[sel_idx] = 1'b0;

    if (disp_fire) begin
      valid_d[alloc_idx]   = 1'b1;
      payload_d[alloc_idx] = rs.dispatch_payload;
      rd_tag_d[alloc_idx]  = rs.dispatch_rd_rob_idx;
      rs1_tag_d[alloc_idx] = rs.dispatch_rs1_rob_idx;
      rs2_tag_d[alloc_idx] = rs.dispatch_rs2_rob_idx;
      {rs1_rdy_d[alloc_idx], rs1_data_d[alloc_idx]} =
        snoop(rs.dispatch_rs1_ready, rs.dispatch_rs1_data, rs.dispatch_rs1_rob_idx,
              rs.cdb_valid, rs.cdb_rob_idx, rs.cdb_data);
      {rs2_rdy_d[alloc_idx], rs2_data_d[alloc_idx]} =
        snoop(rs.dispatch_rs2_ready, rs.dispatch_rs2_data, rs.dispatch_rs2_rob_idx,
              rs.cdb_valid, rs.cdb_rob_idx, rs.cdb_data);
      for (int j = 0; j < int'(DEPTH); j++) older_d[j][alloc_idx] = 1'b1;
      older_d[alloc_idx] = '0;
    end

    if (rs.flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Entry contents are qualified by valid_q and need no reset.
  always_ff @(posedge clk) begin
    rs1_rdy_q  <= rs1_rdy_d;
    rs2_rdy_q  <= rs2_rdy_d;
    payload_q  <= payload_d;
    rd_tag_q   <= rd_tag_d;
    rs1_data_q <= rs1_data_d;
    rs1_tag_q  <= rs1_tag_d;
    rs2_data_q <= rs2_data_d;
    rs2_tag_q  <= rs2_tag_d;
    older_q    <= older_d;
  end
endmodule
